// File: rtl/regfile_writeback.sv
`default_nettype none
// ============================================================================
//  Module      : regfile_writeback
//  Description : Write-back stage in front of the register file. Arbitrates
//                ALU and multi-cycle results, buffers them in a FIFO, drives
//                the registered write port and tracks pending destinations.
//                Optional forwarding lookup enabled by REGFILE_WB_BYPASS_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
module regfile_writeback #(
    parameter int DATA_W     = 16,
    parameter int ADDR_W     = 4,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          alu_valid,
    output logic                          alu_ready,
    input  logic [ADDR_W-1:0]             alu_rd,
    input  logic [DATA_W-1:0]             alu_data,
    input  logic                          mc_valid,
    output logic                          mc_ready,
    input  logic [ADDR_W-1:0]             mc_rd,
    input  logic [DATA_W-1:0]             mc_data,
    input  logic                          issue_valid,
    input  logic [ADDR_W-1:0]             issue_rd,
    input  logic                          wb_stall,
    output logic                          regWrite,
    output logic [ADDR_W-1:0]             A3,
    output logic [DATA_W-1:0]             WD3,
    output logic [2**ADDR_W-1:0]          pending,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count
`ifdef REGFILE_WB_BYPASS_EN
    ,
    input  logic [ADDR_W-1:0]             fwd_addr1,
    input  logic [ADDR_W-1:0]             fwd_addr2,
    output logic                          fwd_hit1,
    output logic                          fwd_hit2,
    output logic [DATA_W-1:0]             fwd_data1,
    output logic [DATA_W-1:0]             fwd_data2
`endif
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int NREG  = 2**ADDR_W;
    localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(FIFO_DEPTH);

    logic [ADDR_W-1:0] buf_rd   [FIFO_DEPTH];
    logic [DATA_W-1:0] buf_data [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic              rr_mc;

    logic              full;
    logic              empty;
    logic              contended;
    logic              grant_alu;
    logic              grant_mc;
    logic              push;
    logic              pop;
    logic [ADDR_W-1:0] push_rd;
    logic [DATA_W-1:0] push_data;
    logic [NREG-1:0]   clr_mask;
    logic [NREG-1:0]   set_mask;

    // Ready is withheld whenever full, even if a pop would free a slot.
    always_comb begin
        full      = (fifo_count == DEPTH_CNT);
        empty     = (fifo_count == '0);
        contended = alu_valid && mc_valid;
        grant_alu = alu_valid && (!mc_valid || !rr_mc);
        grant_mc  = mc_valid && (!alu_valid || rr_mc);
        alu_ready = grant_alu && !full;
        mc_ready  = grant_mc && !full;
        push      = alu_ready || mc_ready;
        push_rd   = alu_ready ? alu_rd   : mc_rd;
        push_data = alu_ready ? alu_data : mc_data;
        pop       = !empty && !wb_stall;
    end

    always_ff @(posedge clk) begin
        if (push) begin
            buf_rd[wr_ptr]   <= push_rd;
            buf_data[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
            rr_mc      <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   fifo_count <= fifo_count + CNT_W'(1);
                2'b01:   fifo_count <= fifo_count - CNT_W'(1);
                default: fifo_count <= fifo_count;
            endcase
            if (contended && push) begin
                rr_mc <= !rr_mc;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            regWrite <= 1'b0;
            A3       <= '0;
            WD3      <= '0;
        end else if (pop) begin
            regWrite <= 1'b1;
            A3       <= buf_rd[rd_ptr];
            WD3      <= buf_data[rd_ptr];
        end else begin
            regWrite <= 1'b0;
        end
    end

    // A same-edge issue wins over the commit clear of that register.
    always_comb begin
        clr_mask = '0;
        set_mask = '0;
        if (regWrite) begin
            clr_mask[A3] = 1'b1;
        end
        if (issue_valid) begin
            set_mask[issue_rd] = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pending <= '0;
        end else begin
            pending <= (pending & ~clr_mask) | set_mask;
        end
    end

`ifdef REGFILE_WB_BYPASS_EN
    logic [PTR_W-1:0] fwd_idx;
    logic             fwd_live;

    // Scan oldest to newest so the youngest matching entry overrides.
    always_comb begin
        fwd_hit1  = 1'b0;
        fwd_hit2  = 1'b0;
        fwd_data1 = '0;
        fwd_data2 = '0;
        fwd_idx   = '0;
        fwd_live  = 1'b0;
        if (regWrite && (A3 == fwd_addr1)) begin
            fwd_hit1  = 1'b1;
            fwd_data1 = WD3;
        end
        if (regWrite && (A3 == fwd_addr2)) begin
            fwd_hit2  = 1'b1;
            fwd_data2 = WD3;
        end
        for (int i = 0; i < FIFO_DEPTH; i++) begin
            fwd_idx  = rd_ptr + PTR_W'(i);
            fwd_live = (CNT_W'(i) < fifo_count);
            if (fwd_live && (buf_rd[fwd_idx] == fwd_addr1)) begin
                fwd_hit1  = 1'b1;
                fwd_data1 = buf_data[fwd_idx];
            end
            if (fwd_live && (buf_rd[fwd_idx] == fwd_addr2)) begin
                fwd_hit2  = 1'b1;
                fwd_data2 = buf_data[fwd_idx];
            end
        end
    end
`endif

endmodule
`default_nettype wire

// File: tb/tb_regfile_writeback.sv
`default_nettype none
// Testbench for regfile_writeback: queue-based reference model with a
// scoreboard monitor that checks every register file write in order.
module tb_regfile_writeback;

    localparam int DATA_W     = 16;
    localparam int ADDR_W     = 4;
    localparam int FIFO_DEPTH = 4;
    localparam int NREG       = 16;

    logic              clk = 1'b0;
    logic              rst;
    logic              alu_valid, alu_ready, mc_valid, mc_ready;
    logic [ADDR_W-1:0] alu_rd, mc_rd, issue_rd, A3;
    logic [DATA_W-1:0] alu_data, mc_data, WD3;
    logic              issue_valid, wb_stall, regWrite;
    logic [NREG-1:0]   pending;
    logic [2:0]        fifo_count;
`ifdef REGFILE_WB_BYPASS_EN
    logic [ADDR_W-1:0] fwd_addr1, fwd_addr2;
    logic              fwd_hit1, fwd_hit2;
    logic [DATA_W-1:0] fwd_data1, fwd_data2;
`endif

    regfile_writeback #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .FIFO_DEPTH(FIFO_DEPTH)) dut (
        .clk(clk), .rst(rst),
        .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_rd(alu_rd), .alu_data(alu_data),
        .mc_valid(mc_valid), .mc_ready(mc_ready), .mc_rd(mc_rd), .mc_data(mc_data),
        .issue_valid(issue_valid), .issue_rd(issue_rd), .wb_stall(wb_stall),
        .regWrite(regWrite), .A3(A3), .WD3(WD3), .pending(pending), .fifo_count(fifo_count)
`ifdef REGFILE_WB_BYPASS_EN
        , .fwd_addr1(fwd_addr1), .fwd_addr2(fwd_addr2), .fwd_hit1(fwd_hit1), .fwd_hit2(fwd_hit2),
        .fwd_data1(fwd_data1), .fwd_data2(fwd_data2)
`endif
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [ADDR_W-1:0] rd;
        logic [DATA_W-1:0] data;
    } ent_t;

    ent_t              fifo_q[$];
    ent_t              wb_q[$];
    ent_t              mon_e;
    bit                rr_mc;
    bit                wr_valid;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic [NREG-1:0]   pend_m;
    logic [ADDR_W-1:0] fa1, fa2;
    logic              last_hit1;
    logic [DATA_W-1:0] last_data1;
    int                n_checks = 0;
    int                n_pass = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    function automatic logic [DATA_W:0] model_fwd(input logic [ADDR_W-1:0] a);
        for (int i = fifo_q.size() - 1; i >= 0; i--)
            if (fifo_q[i].rd == a) return {1'b1, fifo_q[i].data};
        if (wr_valid && wr_addr == a) return {1'b1, wr_data};
        return '0;
    endfunction

    // One clock: drive at negedge, check readies, then apply the edge to the model.
    task automatic step(input bit av, input logic [ADDR_W-1:0] ard, input logic [DATA_W-1:0] ad,
                        input bit mv, input logic [ADDR_W-1:0] mrd, input logic [DATA_W-1:0] md,
                        input bit iv, input logic [ADDR_W-1:0] ird, input bit st);
        bit   full, ga, gm;
        ent_t e;
        logic [DATA_W:0] m;
        @(negedge clk);
        alu_valid = av; alu_rd = ard; alu_data = ad;
        mc_valid = mv; mc_rd = mrd; mc_data = md;
        issue_valid = iv; issue_rd = ird; wb_stall = st;
`ifdef REGFILE_WB_BYPASS_EN
        fwd_addr1 = fa1; fwd_addr2 = fa2;
`endif
        #1;
        full = (fifo_q.size() == FIFO_DEPTH);
        ga = av && (!mv || !rr_mc) && !full;
        gm = mv && (!av || rr_mc) && !full;
        check("alu_ready", alu_ready, ga);
        check("mc_ready", mc_ready, gm);
`ifdef REGFILE_WB_BYPASS_EN
        m = model_fwd(fa1);
        check("fwd_hit1", fwd_hit1, m[DATA_W]);
        check("fwd_data1", fwd_data1, m[DATA_W-1:0]);
        m = model_fwd(fa2);
        check("fwd_hit2", fwd_hit2, m[DATA_W]);
        check("fwd_data2", fwd_data2, m[DATA_W-1:0]);
        last_hit1 = fwd_hit1; last_data1 = fwd_data1;
`endif
        @(posedge clk);
        if (wr_valid) pend_m[wr_addr] = 1'b0;
        if (iv) pend_m[ird] = 1'b1;
        if (fifo_q.size() != 0 && !st) begin
            e = fifo_q.pop_front();
            wb_q.push_back(e);
            wr_valid = 1'b1; wr_addr = e.rd; wr_data = e.data;
        end else begin
            wr_valid = 1'b0;
        end
        if (ga || gm) begin
            e.rd = ga ? ard : mrd;
            e.data = ga ? ad : md;
            fifo_q.push_back(e);
            if (av && mv) rr_mc = !rr_mc;
        end
        #1;
        check("fifo_count", fifo_count, fifo_q.size());
        check("pending", pending, pend_m);
    endtask

    task automatic idle(input bit st);
        step(0, ADDR_W'($urandom), DATA_W'($urandom), 0, ADDR_W'($urandom), DATA_W'($urandom), 0, 0, st);
    endtask

    task automatic model_clear();
        fifo_q.delete(); wb_q.delete();
        wr_valid = 0; pend_m = '0; rr_mc = 0;
    endtask

    task automatic reset_async();
        @(negedge clk);
        #2 rst = 1'b1;
        model_clear();
        #1;
        check("rst_regWrite", regWrite, 0);
        check("rst_pending", pending, 0);
        check("rst_fifo_count", fifo_count, 0);
        check("rst_A3", A3, 0);
        check("rst_WD3", WD3, 0);
        @(negedge clk);
        rst = 1'b0;
    endtask

    // Scoreboard monitor: every write must match the next expected commit.
    always @(posedge clk) begin
        #1;
        if (regWrite === 1'b1 || wb_q.size() != 0) begin
            check("regWrite", regWrite, wb_q.size() != 0);
            if (wb_q.size() != 0) begin
                mon_e = wb_q.pop_front();
                check("A3", A3, mon_e.rd);
                check("WD3", WD3, mon_e.data);
            end
        end
    end

    initial begin
        rst = 1'b1;
        alu_valid = 0; mc_valid = 0; issue_valid = 0; wb_stall = 0;
        alu_rd = 0; mc_rd = 0; issue_rd = 0; alu_data = 0; mc_data = 0;
        fa1 = 0; fa2 = 0; last_hit1 = 0; last_data1 = 0;
`ifdef REGFILE_WB_BYPASS_EN
        fwd_addr1 = 0; fwd_addr2 = 0;
`endif
        model_clear();
        repeat (2) @(negedge clk);
        #1;
        check("init_regWrite", regWrite, 0);
        check("init_pending", pending, 0);
        check("init_fifo_count", fifo_count, 0);
        rst = 1'b0;

        // Latency: accept at edge k, write visible after edge k+1.
        step(1, 4'd1, 16'h1234, 0, 0, 0, 1, 4'd1, 0);
        repeat (3) idle(0);

        // Contention alternates ALU, MC, ALU, MC.
        for (int i = 0; i < 4; i++)
            step(1, 4'd2, 16'hABCD + 16'(i), 1, 4'd3, 16'h5555 + 16'(i), 0, 0, 0);
        repeat (4) idle(0);

        // Stall fills the buffer; release drains four writes.
        for (int i = 0; i < 5; i++)
            step(1, ADDR_W'(i + 8), 16'h0100 + 16'(i), 0, 0, 0, 0, 0, 1);
        check("stall_full_count", fifo_count, 4);
        repeat (6) idle(0);

        // Issue on the same edge as a commit of the same register.
        step(1, 4'd5, 16'h0505, 0, 0, 0, 0, 0, 0);
        idle(0);
        step(0, 0, 0, 0, 0, 0, 1, 4'd5, 0);
        check("pend5_same_edge", pending[5], 1);
        idle(0);

        // Asynchronous reset with three buffered entries and a write in flight.
        for (int i = 0; i < 4; i++)
            step(1, ADDR_W'(i), 16'h0A00 + 16'(i), 0, 0, 0, 1, ADDR_W'(i), 1);
        idle(0);
        check("pre_rst_count", fifo_count, 3);
        check("pre_rst_regWrite", regWrite, 1);
        reset_async();
        repeat (4) idle(0);

`ifdef REGFILE_WB_BYPASS_EN
        fa1 = 4'd7; fa2 = 4'd3;
        step(1, 4'd7, 16'h0001, 0, 0, 0, 0, 0, 1);
        step(1, 4'd7, 16'h0002, 0, 0, 0, 0, 0, 1);
        idle(1);
        check("bypass_hit", last_hit1, 1);
        check("bypass_data", last_data1, 16'h0002);
        repeat (4) idle(0);
`endif

        // Randomized traffic with mixed stall and contention density.
        for (int i = 0; i < 1500; i++) begin
            fa1 = ADDR_W'($urandom); fa2 = ADDR_W'($urandom);
            step($urandom_range(0, 9) < 6, ADDR_W'($urandom), DATA_W'($urandom),
                 $urandom_range(0, 9) < 5, ADDR_W'($urandom), DATA_W'($urandom),
                 $urandom_range(0, 9) < 3, ADDR_W'($urandom),
                 $urandom_range(0, 9) < ((i / 300) % 2 == 0 ? 2 : 6));
        end
        repeat (8) idle(0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
